// File: rtl/uart_tx_slave_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS layout, FSM encoding and reset divisor.
package uart_tx_slave_pkg;

  localparam int unsigned BusW   = 32;
  localparam int unsigned DivW   = 16;
  localparam int unsigned ByteW  = 8;

  localparam logic [DivW-1:0] UartDefaultDiv = 16'd434;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] UartTxData = 2'd0;
  localparam logic [1:0] UartStatus = 2'd1;
  localparam logic [1:0] UartDiv    = 2'd2;
  localparam logic [1:0] UartCtrl   = 2'd3;

  // STATUS bit positions
  localparam int unsigned StEmptyBit = 0;
  localparam int unsigned StFullBit  = 1;
  localparam int unsigned StBusyBit  = 2;
  localparam int unsigned StOvfBit   = 3;

  typedef struct packed {
    logic ovf;
    logic busy;
    logic full;
    logic empty;
  } status_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A stored divisor of zero is treated as one cycle per bit.
  function automatic logic [DivW-1:0] eff_div(input logic [DivW-1:0] d);
    return (d == '0) ? DivW'(1) : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [CntW-1:0]  wr_q, wr_d;
  logic [CntW-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (count_o == CntW'(DEPTH));
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + CntW'(1);
    if (do_pop)  rd_d = rd_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_slave.sv
// Bus-attached UART transmitter: register file, combinational read mux,
// TX FIFO and the 8N1 bit-timing state machine.
module uart_tx_slave
  import uart_tx_slave_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH  = 8,
  parameter logic [DivW-1:0] DEFAULT_DIV = UartDefaultDiv
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            we,
  input  logic [BusW-1:0] addr,
  input  logic [3:0]      sel,
  input  logic [BusW-1:0] data_i,
  output logic [BusW-1:0] data_o,
  output logic            txd_o,
  output logic            irq_o
);

  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);

  logic [1:0]      reg_sel;
  logic            wr_en;
  logic            push_req;
  logic            pop_c;
  logic            busy;

  logic            en_q, en_d;
  logic            irq_en_q, irq_en_d;
  logic            ovf_q, ovf_d;
  logic [DivW-1:0] div_q, div_d;

  tx_state_e       state_q, state_d;
  logic [DivW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [ByteW-1:0] shift_q, shift_d;
  logic            txd_q, txd_d;

  logic [ByteW-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FifoAw:0] fifo_count;
  logic            unused_bus;
  status_t         status;

  assign reg_sel  = addr[3:2];
  assign wr_en    = ce & we;
  assign push_req = wr_en & (reg_sel == UartTxData) & sel[0];
  assign busy     = (state_q != TX_IDLE);
  assign txd_o    = txd_q;
  assign irq_o    = irq_en_q & fifo_empty & ~busy;

  assign unused_bus = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16], fifo_count};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ByteW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .pop_i   (pop_c),
    .data_i  (data_i[7:0]),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register file next-state
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push_req && fifo_full && !pop_c) begin
      ovf_d = 1'b1;
    end else if (wr_en && (reg_sel == UartStatus) && sel[0] && data_i[StOvfBit]) begin
      ovf_d = 1'b0;
    end
    if (wr_en && (reg_sel == UartDiv)) begin
      if (sel[0]) div_d[7:0]  = data_i[7:0];
      if (sel[1]) div_d[15:8] = data_i[15:8];
    end
    if (wr_en && (reg_sel == UartCtrl) && sel[0]) begin
      en_d     = data_i[0];
      irq_en_d = data_i[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  // Read mux: same-cycle, zero unless a read is selected
  always_comb begin
    status       = '0;
    status.ovf   = ovf_q;
    status.busy  = busy;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    data_o       = '0;
    if (ce && !we) begin
      case (reg_sel)
        UartStatus: data_o = BusW'(status);
        UartDiv:    data_o = BusW'(div_q);
        UartCtrl:   data_o = BusW'({irq_en_q, en_q});
        default:    data_o = '0;
      endcase
    end
  end

  // TX FSM: counter reloads from the divisor at every bit boundary
  always_comb begin
    logic            bit_end;
    logic            start_ok;
    logic [DivW-1:0] reload;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop_c    = 1'b0;
    bit_end  = (cnt_q == '0);
    start_ok = en_q & ~fifo_empty;
    reload   = eff_div(div_q) - DivW'(1);
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (start_ok) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = reload;
          txd_d   = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = reload;
          idx_d   = '0;
          txd_d   = shift_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = reload;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (start_ok) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            cnt_d   = reload;
            txd_d   = 1'b0;
            state_d = TX_START;
          end else begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule
